ahb_master_arbiter: RTL

//  Shares one AHB master port (HSEL/HADDR/HTRANS/HWRITE/HWDATA out; HRDATA/HRESP/HREADY_OUT in)

---
 rtl/ahb_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 39 +++
 rtl/ahb_master_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB encodings and arbiter state type for the multi-requester AHB master.
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        OKAY  = 2'b00,
        ERROR = 2'b01,
        RETRY = 2'b10,
        SPLIT = 2'b11
    } hresp_t;

    // Mirrors which of the address/data slots hold a transfer.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ADDR       = 3'd1,
        ST_DATA       = 3'd2,
        ST_ADDR_DATA  = 3'd3,
        ST_ERR_CANCEL = 3'd4
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer and
// moves the pointer past the winner whenever the grant is consumed.
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [N-1:0]   req_i,
    input  logic           advance_i,
    output logic [N-1:0]   grant_o,
    output logic [IDW-1:0] grant_id_o,
    output logic           any_o
);

    logic [IDW-1:0] ptr_q;

    always_comb begin
        any_o      = 1'b0;
        grant_id_o = '0;
        grant_o    = '0;
        for (int i = 0; i < N; i++) begin
            if (!any_o && req_i[(int'(ptr_q) + i) % N]) begin
                any_o      = 1'b1;
                grant_id_o = IDW'((int'(ptr_q) + i) % N);
            end
        end
        grant_o[grant_id_o] = any_o;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else if (advance_i && any_o) begin
            ptr_q <= (grant_id_o == IDW'(N - 1)) ? '0 : grant_id_o + 1'b1;
        end
    end

endmodule

// File: rtl/ahb_master_arbiter.sv
// Shares one AHB master port among NUM_REQ valid/ready requesters using single
// NONSEQ transfers with overlapped address and data phases.
module ahb_master_arbiter
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4
) (
    input  logic                          HCLK,
    input  logic                          HRESET,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic                          HSEL,
    output logic [ADDR_WIDTH-1:0]         HADDR,
    output logic [1:0]                    HTRANS,
    output logic                          HWRITE,
    output logic [DATA_WIDTH-1:0]         HWDATA,
    input  logic [DATA_WIDTH-1:0]         HRDATA,
    input  logic [1:0]                    HRESP,
    input  logic                          HREADY_OUT
);

    localparam int IDW = $clog2(NUM_REQ);

    arb_state_t            state_q, state_d;
    logic [IDW-1:0]        a_id_q, d_id_q;
    logic [ADDR_WIDTH-1:0] a_addr_q;
    logic                  a_write_q, d_write_q;
    logic [DATA_WIDTH-1:0] a_wdata_q, d_wdata_q;
    logic [NUM_REQ-1:0]    rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  rsp_err_q;

    logic                  a_full, d_full, cancel, accept, complete, err1, resp_bad;
    logic                  adv_ok, load, any_req, a_full_d, d_full_d;
    logic [NUM_REQ-1:0]    grant, d_onehot;
    logic [IDW-1:0]        grant_id;

    assign a_full   = (state_q == ST_ADDR) || (state_q == ST_ADDR_DATA) || (state_q == ST_ERR_CANCEL);
    assign d_full   = (state_q == ST_DATA) || (state_q == ST_ADDR_DATA) || (state_q == ST_ERR_CANCEL);
    assign cancel   = (state_q == ST_ERR_CANCEL);
    assign resp_bad = (HRESP != OKAY);
    assign accept   = a_full && !cancel && HREADY_OUT;
    assign complete = d_full && HREADY_OUT;
    // First cycle of a two-cycle error response: the pending address must be withdrawn.
    assign err1     = d_full && !HREADY_OUT && resp_bad;
    assign adv_ok   = !HRESET && HREADY_OUT && (!a_full || accept) && !err1;
    assign load     = adv_ok && any_req;
    assign a_full_d = load || (a_full && !accept);
    assign d_full_d = accept || (d_full && !complete);

    rr_arbiter #(.N(NUM_REQ), .IDW(IDW)) u_rr (
        .clk_i      (HCLK),
        .rst_i      (HRESET),
        .req_i      (req_valid),
        .advance_i  (adv_ok),
        .grant_o    (grant),
        .grant_id_o (grant_id),
        .any_o      (any_req)
    );

    always_comb begin
        state_d = ST_IDLE;
        if (err1 && a_full) begin
            state_d = ST_ERR_CANCEL;
        end else begin
            case ({a_full_d, d_full_d})
                2'b10:   state_d = ST_ADDR;
                2'b01:   state_d = ST_DATA;
                2'b11:   state_d = ST_ADDR_DATA;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        d_onehot         = '0;
        d_onehot[d_id_q] = 1'b1;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            a_id_q      <= '0;
            a_addr_q    <= '0;
            a_write_q   <= 1'b0;
            a_wdata_q   <= '0;
            d_id_q      <= '0;
            d_write_q   <= 1'b0;
            d_wdata_q   <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                a_id_q    <= grant_id;
                a_addr_q  <= req_addr[int'(grant_id)*ADDR_WIDTH +: ADDR_WIDTH];
                a_write_q <= req_write[grant_id];
                a_wdata_q <= req_wdata[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
            end
            if (accept) begin
                d_id_q    <= a_id_q;
                d_write_q <= a_write_q;
                d_wdata_q <= a_wdata_q;
            end
            rsp_valid_q <= complete ? d_onehot : '0;
            rsp_rdata_q <= (complete && !d_write_q) ? HRDATA : '0;
            rsp_err_q   <= complete && resp_bad;
        end
    end

    assign req_ready = grant & {NUM_REQ{adv_ok}};
    assign HSEL      = a_full && !cancel;
    assign HTRANS    = (a_full && !cancel) ? NONSEQ : IDLE;
    assign HADDR     = a_addr_q;
    assign HWRITE    = a_write_q;
    assign HWDATA    = d_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
